carry_serial_addsub: RTL and testbench
======================================

CARRY_SERIAL_ADDSUB -- requirements
Module: carry_serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port IN_VALID, input, 1 bit: operand request.
REQ-005 The block SHALL have port IN_READY, output, 1 bit: the block can accept an operand.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port SUB, input, 1 bit: 1 selects A-B, 0 selects A+B.
REQ-009 The block SHALL have port CI_INIT, input, 1 bit: external carry-in for the LSB.
REQ-010 The block SHALL have port OUT_VALID, output, 1 bit: result available.
REQ-011 The block SHALL have port OUT_READY, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port O, output, WIDTH bits: sum or difference.
REQ-013 The block SHALL have port CO, output, 1 bit: carry out of the MSB; for subtract, 1 means no borrow.
REQ-014 The block SHALL have port OVF, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The block SHALL be a three-state FSM with states IDLE, RUN and DONE.
REQ-016 IN_READY SHALL be 1 only in IDLE; OUT_VALID SHALL be 1 only in DONE.
REQ-017 In IDLE, when IN_VALID=1 at a rising edge, the block SHALL:
- capture A into opA;
- capture B, or ~B when SUB=1, into opB;
- set the carry register c = CI_INIT | SUB;
- clear the bit index i to 0;
- move to RUN.
REQ-018 In IDLE, when IN_VALID=0, the block SHALL hold all registers unchanged.
REQ-019 Each RUN edge SHALL process exactly one bit, LSB first, using the carry-cell recurrence:
- s = opA[i]^opB[i];
- O[i] <= c^s;
- c <= s ? c : opA[i];
- i <= i+1.
REQ-020 On the RUN edge that processes i=WIDTH-1, the block SHALL:
- register the carry into the MSB as cmsb;
- move to DONE.
REQ-021 Latency SHALL be exactly WIDTH cycles: OUT_VALID rises WIDTH edges after the accept edge.
REQ-022 In DONE, the outputs SHALL be CO = c and OVF = c^cmsb.
REQ-023 In DONE, O, CO and OVF SHALL stay stable while OUT_READY=0, with no timeout.
REQ-024 In DONE, OUT_VALID&OUT_READY at an edge SHALL return the FSM to IDLE.
REQ-025 The earliest next accept SHALL be one edge after the result handshake; the minimum period is WIDTH+2 cycles.
REQ-026 IN_VALID, A, B, SUB and CI_INIT SHALL be ignored outside IDLE; a mid-run change SHALL not affect the result.
REQ-027 O, CO and OVF MAY change during RUN; they SHALL be defined only while OUT_VALID=1.
REQ-028 All arithmetic SHALL be modulo 2^WIDTH, with no saturation.
REQ-029 The bit index SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-030 RST_N=0 SHALL immediately, without waiting for CLK, force:
- state IDLE;
- IN_READY=1 and OUT_VALID=0;
- O=0, CO=0 and OVF=0;
- c, cmsb and i to 0.
REQ-031 Reset asserted during RUN or DONE SHALL abort the operation, with no result handshake, and return to the REQ-030 values.
REQ-032 After RST_N deasserts, the block SHALL accept an operand on the first rising edge where IN_VALID=1.

Verification (WIDTH=8)
REQ-033 The bench SHALL cover these scenarios:
- Add carry ripple: A=0x0F, B=0x01, SUB=0, CI_INIT=0 -> OUT_VALID exactly 8 edges after accept; O=0x10, CO=0, OVF=0.
- Wrap: A=0xFF, B=0x01 -> O=0x00, CO=1, OVF=0. With CI_INIT=1 and A=0xFF, B=0x00 -> O=0x00, CO=1.
- Signed overflow: A=0x7F, B=0x01, SUB=0 -> O=0x80, CO=0, OVF=1. A=0x80, B=0x01, SUB=1 -> O=0x7F, CO=1, OVF=1.
- Borrow: A=0x05, B=0x07, SUB=1 -> O=0xFE, CO=0, OVF=0. A=0x07, B=0x05, SUB=1 -> O=0x02, CO=1.
- Backpressure and isolation:
  - hold OUT_READY=0 for 20 cycles in DONE -> O, CO, OVF and OUT_VALID stable; IN_READY=0 throughout;
  - toggling A, B and IN_VALID during RUN does not alter the result;
  - after the handshake, IN_READY=1 on the next cycle.
- Reset: RST_N=0 asynchronously at RUN bit 3 -> IN_READY=1, OUT_VALID=0 and O=0 before the next edge; the next operation 0x12+0x34 -> O=0x46.

Source files
------------

// File: rtl/carry_serial_addsub.sv
// Bit-serial adder/subtractor: one carry-cell step per clock, LSB first.
// Valid/ready on both sides; the result is held in DONE until taken.
module carry_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CI_INIT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] O,
  output logic             CO,
  output logic             OVF
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] o_q;
  logic             c;
  logic             cmsb;
  logic [IW-1:0]    idx;
  logic             s;

  assign s = op_a[idx] ^ op_b[idx];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      o_q   <= '0;
      c     <= 1'b0;
      cmsb  <= 1'b0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            op_a  <= A;
            op_b  <= SUB ? ~B : B;
            c     <= CI_INIT | SUB;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          o_q[idx] <= c ^ s;
          // propagate when bits differ, else generate/kill from op_a
          c <= s ? c : op_a[idx];
          if (idx == LAST) begin
            cmsb  <= c;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (OUT_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign O         = o_q;
  assign CO        = c;
  assign OVF       = c ^ cmsb;

endmodule

// File: tb/tb_carry_serial_addsub.sv
// Self-checking bench for carry_serial_addsub (WIDTH=8): random and
// directed operations compared every cycle against an arithmetic model.
module tb_carry_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       ci_init;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] o;
  logic       co;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  // model: 0 idle, 1 busy, 2 result held
  int         m_st  = 0;
  int         m_cnt = 0;
  logic [9:0] m_exp = '0;

  carry_serial_addsub #(.WIDTH(8)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .A(a),
    .B(b),
    .SUB(sub),
    .CI_INIT(ci_init),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .O(o),
    .CO(co),
    .OVF(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       sb,
    input logic       ci
  );
    logic [7:0] yy;
    logic [8:0] sum;
    logic       v;
    yy  = sb ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + 9'(ci | sb);
    v   = (x[7] == yy[7]) && (sum[7] != x[7]);
    return {v, sum[8], sum[7:0]};
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] req
  );
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(m_st == 0));
    chk("out_valid", 32'(out_valid), 32'(m_st == 2));
    if (m_st == 2) begin
      chk("o", 32'(o), 32'(m_exp[7:0]));
      chk("co", 32'(co), 32'(m_exp[8]));
      chk("ovf", 32'(ovf), 32'(m_exp[9]));
    end
  endtask

  task automatic step();
    logic       acc;
    logic       hs;
    logic [9:0] r;
    acc = (m_st == 0) && in_valid && rst_n;
    hs  = (m_st == 2) && out_ready;
    r   = model(a, b, sub, ci_init);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_st = 0;
    end else begin
      case (m_st)
        0: if (acc) begin
          m_exp = r;
          m_st  = 1;
          m_cnt = 0;
        end
        1: begin
          m_cnt++;
          if (m_cnt == 8) m_st = 2;
        end
        default: if (hs) m_st = 0;
      endcase
      compare();
    end
  endtask

  task automatic run_op(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       sb,
    input logic       ci,
    input int         hold,
    input bit         lit,
    input logic [9:0] lit_exp
  );
    int n;
    n = 0;
    while (m_st != 0 && n < 40) begin
      step();
      n++;
    end
    a         = x;
    b         = y;
    sub       = sb;
    ci_init   = ci;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    n = 0;
    while (m_st == 1 && n < 20) begin
      in_valid = 1'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      sub      = 1'($urandom);
      ci_init  = 1'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0;
    if (m_st != 2) begin
      chk("done_timeout", 32'(m_st), 32'd2);
      return;
    end
    if (lit) begin
      chk("lit_o", 32'(o), 32'(lit_exp[7:0]));
      chk("lit_co", 32'(co), 32'(lit_exp[8]));
      chk("lit_ovf", 32'(ovf), 32'(lit_exp[9]));
    end
    for (int k = 0; k < hold; k++) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    ci_init   = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed: {ovf, co, o}
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b1, {1'b0, 1'b0, 8'h10});
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 1'b1, {1'b0, 1'b1, 8'h00});
    run_op(8'hFF, 8'h00, 1'b0, 1'b1, 0, 1'b1, {1'b0, 1'b1, 8'h00});
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 2, 1'b1, {1'b1, 1'b0, 8'h80});
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 0, 1'b1, {1'b1, 1'b1, 8'h7F});
    run_op(8'h05, 8'h07, 1'b1, 1'b0, 0, 1'b1, {1'b0, 1'b0, 8'hFE});
    run_op(8'h07, 8'h05, 1'b1, 1'b0, 0, 1'b1, {1'b0, 1'b1, 8'h02});
    run_op(8'hA5, 8'h3C, 1'b0, 1'b0, 20, 1'b1, {1'b0, 1'b0, 8'hE1});

    // async reset while bit 3 is next to be processed
    a        = 8'h55;
    b        = 8'h22;
    sub      = 1'b0;
    ci_init  = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    m_st = 0;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_o", 32'(o), 32'd0);
    chk("arst_co", 32'(co), 32'd0);
    step();
    #2;
    rst_n = 1'b1;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b1, {1'b0, 1'b0, 8'h46});

    for (int t = 0; t < 40; t++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'b0, 10'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
